multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Upstream sequencer for the n-bit adder. Accepts one wide add/subtract
//  (WORDS*N bits) over a valid/ready handshake and splits it into N-bit
//  slices. It feeds the slices LSW-first to an external combinational N-bit
//  adder, one slice per cycle, and chains the carry between slices.
//  It collects the slice sums and presents the wide result with flags on
//  a valid/ready output.
// PARAMETERS
//  N      8  adder slice width (bits)
//  WORDS  4  slices per operation (>=1); wide width W = N*WORDS
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, synchronous, active-high
//  in_valid   in   1  operation request
//  in_ready   out  1  sequencer can accept (high only in IDLE)
//  in_a       in   W  operand A
//  in_b       in   W  operand B
//  in_cin     in   1  carry-in (ignored when in_sub=1)
//  in_sub     in   1  1: A-B (B inverted, cin forced 1); 0: A+B+cin
//  add_a      out  N  slice of A to adder
//  add_b      out  N  slice of (possibly inverted) B to adder
//  add_cin    out  1  chained carry to adder
//  add_sum    in   N  adder sum, combinational from add_a/add_b/add_cin
//  add_cout   in   1  adder carry-out
//  out_valid  out  1  result available
//  out_ready  in   1  consumer takes result
//  out_sum    out  W  wide result
//  out_cout   out  1  final carry (subtract: 1 = no borrow)
//  out_ovf    out  1  signed two's-complement overflow
//  out_zero   out  1  out_sum == 0
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational.
//  - Reset: state=IDLE, idx=0, carry=0, operand/result regs=0. out_valid=0,
//    out_sum=0, out_cout=0, out_ovf=0, out_zero=0. add_a/add_b/add_cin=0.
//  - IDLE: on the edge with in_valid&&in_ready, latch A and B' (B' = in_sub ? ~in_b : in_b).
//    Set carry = in_sub ? 1 : in_cin, set idx=0, go to RUN.
//    in_valid while not ready is ignored; no operand is captured.
//  - RUN: add_a = A[idx*N +: N], add_b = B'[idx*N +: N], add_cin = carry.
//    On each edge: result[idx*N +: N] <= add_sum, carry <= add_cout, idx++.
//    On the edge where idx==WORDS-1: out_cout <= add_cout and state -> DONE.
//    On the same edge, load out_ovf and out_zero from the final sum.
//  - out_ovf = (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]).
//  - add_* outputs are 0 outside RUN.
//  - Latency: operation accepted at edge T gives out_valid=1 after edge T+WORDS.
//    WORDS=1 gives a single RUN cycle.
//  - DONE: out_valid=1. out_sum and flags are held stable while out_ready=0.
//    Handshake out_valid&&out_ready -> IDLE next edge with out_valid=0.
//    out_sum and flags keep their last value until the next result loads.
//    One bubble cycle separates operations; DONE does not accept new input.
//  - Arithmetic is modulo 2^W; the final carry is visible only on out_cout.
//  - rst in any state, including mid-RUN or DONE: abort and go to reset values
//    on that edge. The partial result is discarded and no out_valid pulse occurs.
// TESTING (N=8, WORDS=4)
//  1 Hold rst 2 cycles -> in_ready=1, out_valid=0, out_sum=0, add_*=0.
//  2 A=0x000000FF, B=0x00000001, add -> out_sum=0x00000100, cout=0, ovf=0.
//    out_valid rises exactly 4 edges after accept; add_cin=1 in slice 1.
//  3 A=0xFFFFFFFF, B=1 -> sum=0, cout=1, zero=1.
//    A=0x7FFFFFFF, B=1 -> sum=0x80000000, ovf=1.
//  4 Sub A=5, B=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
//    Sub A=0x80000000, B=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
//  5 out_ready low for 5 cycles in DONE with in_valid=1 -> outputs stable.
//    in_ready stays 0 and the new op is not captured until after the handshake.
//  6 rst asserted on the 2nd RUN cycle -> IDLE next edge, out_valid stays 0.
//    The following op A=3, B=4 then gives sum=7.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Splits one WORDS*N-bit add/subtract into N-bit slices for an external adder, LSW first.
// Latency: an operation accepted at edge T shows out_valid after edge T+WORDS.
// Backpressure: in_ready is high only in IDLE; the result and flags are held in DONE until out_ready.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   in_valid/in_ready             operation handshake; in_a, in_b, in_cin, in_sub are the operands
//   add_a/add_b/add_cin           slice driven to the external combinational adder
//   add_sum/add_cout              adder response, used within the same cycle
//   out_valid/out_ready           result handshake; out_sum, out_cout, out_ovf, out_zero are the result
module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
    input  logic               in_sub,
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    output logic               add_cin,
    input  logic [N-1:0]       add_sum,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_ovf,
    output logic               out_zero
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;      // already inverted for subtract
    logic [W-1:0]   res;
    logic [W-1:0]   res_nxt;
    logic           carry;
    logic [IW-1:0]  idx;
    logic           last_slice;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        last_slice = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_a      = op_a[idx*N +: N];
                add_b      = op_b[idx*N +: N];
                add_cin    = carry;
                last_slice = (idx == LAST);
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result with the current slice merged in; on the last slice this is the
    // complete sum, so the output register and flags load from it directly.
    always_comb begin
        res_nxt              = res;
        res_nxt[idx*N +: N]  = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_sub ? ~in_b : in_b;
                        carry <= in_sub | in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nxt;
                    carry <= add_cout;
                    idx   <= idx + IW'(1);
                    if (last_slice) begin
                        out_sum  <= res_nxt;
                        out_cout <= add_cout;
                        out_ovf  <= (op_a[W-1] == op_b[W-1]) && (res_nxt[W-1] != op_a[W-1]);
                        out_zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed corner cases plus random operations.
// An external N-bit adder is modelled combinationally; a per-cycle checker
// compares every output against a whole-word arithmetic model.
module tb_multiword_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // External adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic              busy = 1'b0;
    int                acc_cyc = 0;
    longint unsigned   ea, eb, ecin, esum;
    logic [W-1:0]      last_sum = '0;
    logic              last_cout = 1'b0, last_ovf = 1'b0, last_zero = 1'b0;
    logic              ev, e_ovf, e_zero;
    int                d, k;
    longint unsigned   mask, sa, sb, scin;

    always @(negedge clk) begin
        if (rst) begin
            busy      = 1'b0;
            last_sum  = '0;
            last_cout = 1'b0;
            last_ovf  = 1'b0;
            last_zero = 1'b0;
        end else begin
            d  = cyc - acc_cyc;
            ev = busy && (d >= WORDS + 1);
            e_ovf  = (ea[W-1] == eb[W-1]) && (esum[W-1] != ea[W-1]);
            e_zero = (esum[W-1:0] == 0);
            chk("in_ready", {63'd0, in_ready}, {63'd0, !busy});
            chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
            if (busy && d >= 1 && d <= WORDS) begin
                k    = d - 1;
                mask = (64'd1 << (k * N)) - 64'd1;
                sa   = (ea >> (k * N)) & 64'hFF;
                sb   = (eb >> (k * N)) & 64'hFF;
                scin = (((ea & mask) + (eb & mask) + ecin) >> (k * N)) & 64'd1;
            end else begin
                sa = 0; sb = 0; scin = 0;
            end
            chk("add_a", {56'd0, add_a}, sa);
            chk("add_b", {56'd0, add_b}, sb);
            chk("add_cin", {63'd0, add_cin}, scin);
            chk("out_sum", {32'd0, out_sum}, ev ? {32'd0, esum[W-1:0]} : {32'd0, last_sum});
            chk("out_cout", {63'd0, out_cout}, ev ? {63'd0, esum[W]} : {63'd0, last_cout});
            chk("out_ovf", {63'd0, out_ovf}, ev ? {63'd0, e_ovf} : {63'd0, last_ovf});
            chk("out_zero", {63'd0, out_zero}, ev ? {63'd0, e_zero} : {63'd0, last_zero});
            if (in_valid && !busy) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                ea      = {32'd0, in_a};
                eb      = {32'd0, (in_sub ? ~in_b : in_b)};
                ecin    = (in_sub || in_cin) ? 1 : 0;
                esum    = ea + eb + ecin;
            end else if (ev && out_ready) begin
                busy      = 1'b0;
                last_sum  = esum[W-1:0];
                last_cout = esum[W];
                last_ovf  = e_ovf;
                last_zero = e_zero;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit ok = 0;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_wait", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until out_valid; start = negedges already consumed.
    task automatic wait_out(input int start);
        int seen = 0;
        for (int i = start + 1; i <= start + 20; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = i; break; end
        end
        chk("latency", seen, WORDS + 1);
    endtask

    task automatic release_out(input int hold);
        repeat (hold + 1) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic chk_res(input string name, input logic [W-1:0] s, input logic c,
                           input logic o, input logic z);
        chk({name, "_sum"}, {32'd0, out_sum}, {32'd0, s});
        chk({name, "_cout"}, {63'd0, out_cout}, {63'd0, c});
        chk({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, o});
        chk({name, "_zero"}, {63'd0, out_zero}, {63'd0, z});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_add", {47'd0, add_a, add_b, add_cin}, 64'd0);

        // Carry ripples from slice 0 into slice 1
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("slice1_cin", {63'd0, add_cin}, 64'd1);
        wait_out(2);
        chk_res("ff_plus_1", 32'h00000100, 1'b0, 1'b0, 1'b0);
        release_out(0);

        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_out(0);
        chk_res("wrap", 32'h00000000, 1'b1, 1'b0, 1'b1);
        release_out(1);

        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_out(0);
        chk_res("pos_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
        release_out(0);

        // in_cin must be ignored on subtract
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        wait_out(0);
        chk_res("sub_neg", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        release_out(0);

        send(32'h80000000, 32'h00000001, 1'b0, 1'b1);
        wait_out(0);
        chk_res("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        release_out(2);

        // DONE holds while out_ready is low; a pending request waits for the handshake
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        wait_out(0);
        @(posedge clk); #1;
        in_a = 32'h00000010; in_b = 32'h00000010; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_in_ready", {63'd0, in_ready}, 64'd0);
            chk("done_hold_sum", {32'd0, out_sum}, 64'h23456789);
        end
        release_out(0);
        @(negedge clk);
        chk("after_hs_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_out(0);
        chk_res("queued_sub", 32'h00000000, 1'b1, 1'b0, 1'b1);
        release_out(0);

        // Reset during the second RUN cycle aborts the operation
        send(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        send(32'h00000003, 32'h00000004, 1'b0, 1'b0);
        wait_out(0);
        chk_res("after_abort", 32'h00000007, 1'b0, 1'b0, 1'b0);
        release_out(0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'hFFFFFFFF;
            if ($urandom_range(0, 5) == 0) rb = ra;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_out(0);
            release_out($urandom_range(0, 3));
        end
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
